multi_channel_rr_arbiter: RTL and testbench

Round-robin arbiter granting NUM_CHANNELS parallel waveguides to NUM_ROUTERS requesting routers. Each request carries a packet length. The granted channel is held for that many cycles plus a fixed guard interval for optical settling. It sits between the router request fabric and the waveguide drivers, generalising the two-router, single-waveguide, fixed-delay arbiter.

---
 rtl/onoc_arb_pkg.sv | 15 +
 rtl/waveguide_channel_timer.sv | 87 ++++++++
 rtl/multi_channel_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_multi_channel_rr_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/onoc_arb_pkg.sv
// Shared types and helpers for the optical NoC waveguide arbiter.
package onoc_arb_pkg;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_HOLD,
    CH_GUARD
  } chan_state_t;

  // Index width that never collapses to zero bits for single-entry sets.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/waveguide_channel_timer.sv
// One waveguide: IDLE -> HOLD (packet length) -> GUARD (optical settling) -> IDLE,
// with the current owner recorded for the duration.
module waveguide_channel_timer
  import onoc_arb_pkg::*;
#(
  parameter int LEN_W        = 4,
  parameter int RT_W         = 2,
  parameter int GUARD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] start_len,
  input  logic [RT_W-1:0]  start_owner,
  output logic             free,
  output logic             busy,
  output logic [RT_W-1:0]  owner
);

  localparam int GUARD_W = clog2_min1(GUARD_CYCLES + 1);
  localparam int CNT_W   = (LEN_W > GUARD_W) ? LEN_W : GUARD_W;

  chan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RT_W-1:0]  owner_q, owner_d;
  logic             release_now;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    release_now = 1'b0;
    case (state_q)
      CH_HOLD: begin
        if (cnt_q == CNT_W'(1)) begin
          if (GUARD_CYCLES == 0) begin
            state_d     = CH_IDLE;
            owner_d     = '0;
            release_now = 1'b1;
          end else begin
            state_d = CH_GUARD;
            cnt_d   = CNT_W'(GUARD_CYCLES);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CH_GUARD: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d     = CH_IDLE;
          owner_d     = '0;
          release_now = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
    // A channel finishing this cycle is handed straight to the next owner.
    if (start) begin
      state_d = CH_HOLD;
      cnt_d   = (start_len == '0) ? CNT_W'(1) : CNT_W'(start_len);
      owner_d = start_owner;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CH_IDLE;
      cnt_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

  assign free  = (state_q == CH_IDLE) || release_now;
  assign busy  = (state_q != CH_IDLE);
  assign owner = owner_q;

endmodule

// File: rtl/multi_channel_rr_arbiter.sv
// Round-robin assignment of NUM_ROUTERS requesters onto NUM_CHANNELS waveguides,
// each held for the packet length plus a guard interval.
module multi_channel_rr_arbiter
  import onoc_arb_pkg::*;
#(
  parameter  int NUM_ROUTERS  = 4,
  parameter  int NUM_CHANNELS = 2,
  parameter  int LEN_W        = 4,
  parameter  int GUARD_CYCLES = 1,
  localparam int CH_W         = clog2_min1(NUM_CHANNELS),
  localparam int RT_W         = clog2_min1(NUM_ROUTERS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_ROUTERS-1:0]          request,
  input  logic [NUM_ROUTERS*LEN_W-1:0]    req_len,
  output logic [NUM_ROUTERS-1:0]          grant,
  output logic [NUM_ROUTERS*CH_W-1:0]     grant_chan,
  output logic [NUM_CHANNELS-1:0]         chan_busy,
  output logic [NUM_CHANNELS*RT_W-1:0]    chan_owner,
  output logic [NUM_ROUTERS-1:0]          router_active
);

  logic [RT_W-1:0]                 rr_ptr, rr_ptr_d;
  logic [NUM_ROUTERS-1:0]          eligible, grant_d;
  logic [NUM_ROUTERS*CH_W-1:0]     grant_chan_d;
  logic [NUM_CHANNELS-1:0]         chan_free, chan_start, taken;
  logic [NUM_CHANNELS*RT_W-1:0]    start_owner;
  logic [NUM_CHANNELS*LEN_W-1:0]   start_len;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    waveguide_channel_timer #(
      .LEN_W       (LEN_W),
      .RT_W        (RT_W),
      .GUARD_CYCLES(GUARD_CYCLES)
    ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .start      (chan_start[c]),
      .start_len  (start_len[c*LEN_W +: LEN_W]),
      .start_owner(start_owner[c*RT_W +: RT_W]),
      .free       (chan_free[c]),
      .busy       (chan_busy[c]),
      .owner      (chan_owner[c*RT_W +: RT_W])
    );
  end

  always_comb begin
    router_active = '0;
    for (int i = 0; i < NUM_ROUTERS; i++) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (chan_busy[c] && chan_owner[c*RT_W +: RT_W] == RT_W'(i)) router_active[i] = 1'b1;
      end
    end
  end

  assign eligible = request & ~router_active;

  // Walk routers from rr_ptr; each eligible one takes the lowest free channel left.
  always_comb begin
    int  r;
    logic found;
    grant_d      = '0;
    grant_chan_d = '0;
    chan_start   = '0;
    start_owner  = '0;
    start_len    = '0;
    taken        = '0;
    rr_ptr_d     = rr_ptr;
    r            = 0;
    found        = 1'b0;
    for (int k = 0; k < NUM_ROUTERS; k++) begin
      r = int'(rr_ptr) + k;
      if (r >= NUM_ROUTERS) r = r - NUM_ROUTERS;
      found = 1'b0;
      if (eligible[r]) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
          if (!found && chan_free[c] && !taken[c]) begin
            found                          = 1'b1;
            taken[c]                       = 1'b1;
            chan_start[c]                  = 1'b1;
            start_owner[c*RT_W +: RT_W]    = RT_W'(r);
            start_len[c*LEN_W +: LEN_W]    = req_len[r*LEN_W +: LEN_W];
            grant_d[r]                     = 1'b1;
            grant_chan_d[r*CH_W +: CH_W]   = CH_W'(c);
            rr_ptr_d                       = RT_W'((r + 1) % NUM_ROUTERS);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= '0;
      grant_chan <= '0;
      rr_ptr     <= '0;
    end else begin
      grant      <= grant_d;
      grant_chan <= grant_chan_d;
      rr_ptr     <= rr_ptr_d;
    end
  end

  // A router never holds two channels, and simultaneous grants use distinct channels.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int a = 0; a < NUM_CHANNELS; a++) begin
        for (int b = a + 1; b < NUM_CHANNELS; b++) begin
          assert (!(chan_busy[a] && chan_busy[b] &&
                    chan_owner[a*RT_W +: RT_W] == chan_owner[b*RT_W +: RT_W]))
            else $error("router owns two channels");
        end
      end
      for (int i = 0; i < NUM_ROUTERS; i++) begin
        for (int j = i + 1; j < NUM_ROUTERS; j++) begin
          assert (!(grant[i] && grant[j] &&
                    grant_chan[i*CH_W +: CH_W] == grant_chan[j*CH_W +: CH_W]))
            else $error("two grants on one channel");
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_rr_arbiter.sv
// Directed bench: dut_a is 4 routers / 2 channels / guard 1,
// dut_b is 4 routers / 1 channel / guard 0 for the saturation fairness check.
module tb_multi_channel_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  request_a, request_b;
  logic [15:0] req_len_a, req_len_b;
  logic [3:0]  grant_a, grant_b;
  logic [3:0]  grant_chan_a, grant_chan_b;
  logic [1:0]  chan_busy_a;
  logic [0:0]  chan_busy_b;
  logic [3:0]  chan_owner_a;
  logic [1:0]  chan_owner_b;
  logic [3:0]  router_active_a, router_active_b;

  int tests_run;
  int tests_failed;

  multi_channel_rr_arbiter #(
    .NUM_ROUTERS(4), .NUM_CHANNELS(2), .LEN_W(4), .GUARD_CYCLES(1)
  ) dut_a (
    .clk(clk), .rst(rst), .request(request_a), .req_len(req_len_a),
    .grant(grant_a), .grant_chan(grant_chan_a), .chan_busy(chan_busy_a),
    .chan_owner(chan_owner_a), .router_active(router_active_a)
  );

  multi_channel_rr_arbiter #(
    .NUM_ROUTERS(4), .NUM_CHANNELS(1), .LEN_W(4), .GUARD_CYCLES(0)
  ) dut_b (
    .clk(clk), .rst(rst), .request(request_b), .req_len(req_len_b),
    .grant(grant_b), .grant_chan(grant_chan_b), .chan_busy(chan_busy_b),
    .chan_owner(chan_owner_b), .router_active(router_active_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    request_a = '0;
    request_b = '0;
    req_len_a = '0;
    req_len_b = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (dut_a.rr_ptr !== 2'd0) begin
      tests_failed++; $display("FAIL reset_rr_ptr got %0d want 0", dut_a.rr_ptr);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      tests_run++;
      if (grant_a !== 4'b0000 || chan_busy_a !== 2'b00 || chan_owner_a !== 4'h0 ||
          router_active_a !== 4'b0000) begin
        tests_failed++;
        $display("FAIL reset_idle cyc%0d got g=%b busy=%b own=%h act=%b want all 0",
                 k, grant_a, chan_busy_a, chan_owner_a, router_active_a);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    request_a = 4'b0001;
    req_len_a = 16'h0003;
    step();
    tests_run++;
    if (grant_a !== 4'b0001 || grant_chan_a !== 4'h0 || chan_busy_a !== 2'b01 ||
        router_active_a !== 4'b0001 || chan_owner_a !== 4'h0) begin
      tests_failed++;
      $display("FAIL single_grant got g=%b gc=%h busy=%b act=%b own=%h want 0001 0 01 0001 0",
               grant_a, grant_chan_a, chan_busy_a, router_active_a, chan_owner_a);
    end
    request_a = 4'b0000;
    for (int k = 2; k <= 4; k++) begin
      step();
      tests_run++;
      if (grant_a !== 4'b0000 || chan_busy_a !== 2'b01) begin
        tests_failed++;
        $display("FAIL single_hold cyc%0d got g=%b busy=%b want 0000 01", k, grant_a, chan_busy_a);
      end
    end
    step();
    tests_run++;
    if (chan_busy_a !== 2'b00 || router_active_a !== 4'b0000) begin
      tests_failed++;
      $display("FAIL single_release got busy=%b act=%b want 00 0000", chan_busy_a, router_active_a);
    end
    tests_run++;
    if (dut_a.rr_ptr !== 2'd1) begin
      tests_failed++; $display("FAIL single_rr_ptr got %0d want 1", dut_a.rr_ptr);
    end
  endtask

  task automatic test_parallel();
    logic [3:0] exp_g  [7];
    logic [3:0] exp_gc [7];
    exp_g  = '{4'b0011, 4'b0000, 4'b0000, 4'b1100, 4'b0000, 4'b0000, 4'b0011};
    exp_gc = '{4'b0010, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0010};
    do_reset();
    request_a = 4'b1111;
    req_len_a = 16'h2222;
    for (int k = 0; k < 7; k++) begin
      step();
      tests_run++;
      if (grant_a !== exp_g[k] || grant_chan_a !== exp_gc[k] || chan_busy_a !== 2'b11) begin
        tests_failed++;
        $display("FAIL parallel cyc%0d got g=%b gc=%b busy=%b want %b %b 11",
                 k + 1, grant_a, grant_chan_a, chan_busy_a, exp_g[k], exp_gc[k]);
      end
      if (k == 0 || k == 3) begin
        tests_run++;
        if (chan_owner_a !== ((k == 0) ? 4'b0100 : 4'b1110)) begin
          tests_failed++;
          $display("FAIL parallel_owner cyc%0d got %b want %b", k + 1, chan_owner_a,
                   (k == 0) ? 4'b0100 : 4'b1110);
        end
      end
    end
    request_a = 4'b0000;
  endtask

  task automatic test_fairness();
    int         cnt [4];
    logic [3:0] exp;
    cnt = '{0, 0, 0, 0};
    do_reset();
    request_b = 4'b1111;
    req_len_b = 16'h1111;
    for (int k = 0; k < 40; k++) begin
      step();
      exp = 4'b0001 << (k % 4);
      tests_run++;
      if (grant_b !== exp || chan_busy_b !== 1'b1) begin
        tests_failed++;
        $display("FAIL fairness cyc%0d got g=%b busy=%b want %b 1", k + 1, grant_b, chan_busy_b, exp);
      end
      for (int i = 0; i < 4; i++) if (grant_b[i] === 1'b1) cnt[i]++;
    end
    request_b = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (cnt[i] != 10) begin
        tests_failed++; $display("FAIL fairness_share r%0d got %0d want 10", i, cnt[i]);
      end
    end
  endtask

  task automatic test_zero_len();
    logic [3:0] exp_g    [4];
    logic [1:0] exp_busy [4];
    exp_g    = '{4'b0001, 4'b0000, 4'b0000, 4'b0001};
    exp_busy = '{2'b01, 2'b01, 2'b00, 2'b01};
    do_reset();
    request_a = 4'b0001;
    req_len_a = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      step();
      tests_run++;
      if (grant_a !== exp_g[k] || chan_busy_a !== exp_busy[k]) begin
        tests_failed++;
        $display("FAIL zero_len cyc%0d got g=%b busy=%b want %b %b",
                 k + 1, grant_a, chan_busy_a, exp_g[k], exp_busy[k]);
      end
    end
    request_a = 4'b0000;
  endtask

  task automatic test_dropped();
    do_reset();
    request_a = 4'b0010;
    #3;
    request_a = 4'b0000;
    step();
    tests_run++;
    if (grant_a !== 4'b0000 || chan_busy_a !== 2'b00 || dut_a.rr_ptr !== 2'd0) begin
      tests_failed++;
      $display("FAIL dropped got g=%b busy=%b ptr=%0d want 0000 00 0", grant_a, chan_busy_a, dut_a.rr_ptr);
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    request_a = 4'b0100;
    req_len_a = 16'h0F00;
    step();
    tests_run++;
    if (grant_a !== 4'b0100 || grant_chan_a !== 4'h0 || chan_owner_a !== 4'b0010 ||
        router_active_a !== 4'b0100) begin
      tests_failed++;
      $display("FAIL midhold_grant got g=%b gc=%h own=%b act=%b want 0100 0 0010 0100",
               grant_a, grant_chan_a, chan_owner_a, router_active_a);
    end
    request_a = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      step();
      tests_run++;
      if (chan_busy_a !== 2'b01) begin
        tests_failed++; $display("FAIL midhold_busy cyc%0d got %b want 01", k + 2, chan_busy_a);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (chan_busy_a !== 2'b00 || router_active_a !== 4'b0000 || chan_owner_a !== 4'h0 ||
        grant_a !== 4'b0000) begin
      tests_failed++;
      $display("FAIL midhold_async got busy=%b act=%b own=%h g=%b want 00 0000 0 0000",
               chan_busy_a, router_active_a, chan_owner_a, grant_a);
    end
    #2;
    rst = 1'b0;
    step();
    tests_run++;
    if (grant_a !== 4'b0000 || chan_busy_a !== 2'b00) begin
      tests_failed++;
      $display("FAIL midhold_after got g=%b busy=%b want 0000 00", grant_a, chan_busy_a);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    request_a    = '0;
    request_b    = '0;
    req_len_a    = '0;
    req_len_b    = '0;
    test_reset();
    test_single();
    test_parallel();
    test_fairness();
    test_zero_len();
    test_dropped();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
